// File: rtl/shadow_register_restorer_if.sv
// Bundles the restore request, dcache load, shadow-file write and mret
// handshake signals of the shadow register restorer into one port.
interface shadow_register_restorer_if #(
  parameter int ADDR_WIDTH  = 6,
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_WIDTH = 12,
  parameter int TAG_WIDTH   = 22
);
  logic                    restore_valid_i;
  logic                    restore_ack_o;
  logic [DATA_WIDTH-1:0]   frame_sp_i;
  logic                    abort_i;
  logic                    busy_o;
  logic [ADDR_WIDTH-1:0]   load_level_o;
  logic                    shadow_reg_we_o;
  logic [ADDR_WIDTH-1:0]   shadow_reg_waddr_o;
  logic [DATA_WIDTH-1:0]   shadow_reg_wdata_o;
  logic                    data_req_o;
  logic                    data_gnt_i;
  logic [INDEX_WIDTH-1:0]  address_index_o;
  logic [TAG_WIDTH-1:0]    address_tag_o;
  logic                    tag_valid_o;
  logic                    kill_req_o;
  logic                    data_we_o;
  logic [DATA_WIDTH/8-1:0] data_be_o;
  logic [1:0]              data_size_o;
  logic                    data_rvalid_i;
  logic [DATA_WIDTH-1:0]   data_rdata_i;
  logic                    mret_valid_i;
  logic                    mret_ready_o;
  logic [11:0]             page_offset_i;
  logic                    page_offset_matches_o;

  // Restorer side.
  modport master (
    input  restore_valid_i, frame_sp_i, abort_i, data_gnt_i, data_rvalid_i,
           data_rdata_i, mret_valid_i, page_offset_i,
    output restore_ack_o, busy_o, load_level_o, shadow_reg_we_o,
           shadow_reg_waddr_o, shadow_reg_wdata_o, data_req_o, address_index_o,
           address_tag_o, tag_valid_o, kill_req_o, data_we_o, data_be_o,
           data_size_o, mret_ready_o, page_offset_matches_o
  );

  // Environment side (CSR unit, dcache, shadow file, mret logic).
  modport slave (
    output restore_valid_i, frame_sp_i, abort_i, data_gnt_i, data_rvalid_i,
           data_rdata_i, mret_valid_i, page_offset_i,
    input  restore_ack_o, busy_o, load_level_o, shadow_reg_we_o,
           shadow_reg_waddr_o, shadow_reg_wdata_o, data_req_o, address_index_o,
           address_tag_o, tag_valid_o, kill_req_o, data_we_o, data_be_o,
           data_size_o, mret_ready_o, page_offset_matches_o
  );
endinterface

// File: rtl/shadow_register_restorer.sv
// Shadow register restorer: reloads a saved register frame from the dcache
// into the shadow register file, one load outstanding at a time, and holds
// mret until the whole frame is back.
module shadow_register_restorer #(
  parameter int ADDR_WIDTH       = 6,
  parameter int DATA_WIDTH       = 32,
  parameter int NUM_SHADOW_SAVES = 16,
  parameter int INDEX_WIDTH      = 12,
  parameter int TAG_WIDTH        = 22
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  shadow_register_restorer_if.master bus
);

  localparam int BYTES    = DATA_WIDTH / 8;
  localparam int IT_WIDTH = INDEX_WIDTH + TAG_WIDTH;
  localparam logic [DATA_WIDTH-1:0] FRAME_BYTES = DATA_WIDTH'(NUM_SHADOW_SAVES * BYTES);
  localparam logic [DATA_WIDTH-1:0] STEP_BYTES  = DATA_WIDTH'(BYTES);
  localparam logic [ADDR_WIDTH-1:0] NUM_SAVES   = ADDR_WIDTH'(NUM_SHADOW_SAVES);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX    = ADDR_WIDTH'(NUM_SHADOW_SAVES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQ       = 3'd1,
    TAG       = 3'd2,
    WAIT_DATA = 3'd3,
    DRAIN     = 3'd4,
    DONE      = 3'd5
  } state_e;

  state_e                  state_q;
  logic [DATA_WIDTH-1:0]   addr_q;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic [8:0]              frame_end_q;
  logic [IT_WIDTH-1:0]     addr_ext_s;
  logic                    busy_s;
  logic                    in_range_s;
  logic                    unused_page_bits_s;

  // The dcache address split may be wider than XLEN: zero-extend, else truncate.
  generate
    if (DATA_WIDTH >= IT_WIDTH) begin : g_addr_trunc
      assign addr_ext_s = addr_q[IT_WIDTH-1:0];
    end else begin : g_addr_ext
      assign addr_ext_s = {{(IT_WIDTH - DATA_WIDTH){1'b0}}, addr_q};
    end
  endgenerate

  assign unused_page_bits_s = ^bus.page_offset_i[2:0];

  // Sequencer: accept, request, tag, wait for data, and abort/drain handling.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      addr_q      <= {DATA_WIDTH{1'b0}};
      idx_q       <= {ADDR_WIDTH{1'b0}};
      frame_end_q <= 9'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.restore_valid_i) begin
            addr_q      <= bus.frame_sp_i - FRAME_BYTES;
            frame_end_q <= bus.frame_sp_i[11:3];
            idx_q       <= {ADDR_WIDTH{1'b0}};
            state_q     <= REQ;
          end
        end
        REQ: begin
          if (bus.abort_i) begin
            state_q <= IDLE;
          end else if (bus.data_gnt_i) begin
            state_q <= TAG;
          end
        end
        TAG: begin
          // Any rvalid seen here cannot belong to this load and is ignored.
          state_q <= bus.abort_i ? IDLE : WAIT_DATA;
        end
        WAIT_DATA: begin
          if (bus.abort_i) begin
            // The outstanding load still returns unless it lands right now.
            state_q <= bus.data_rvalid_i ? IDLE : DRAIN;
          end else if (bus.data_rvalid_i) begin
            if (idx_q == LAST_IDX) begin
              state_q <= DONE;
            end else begin
              idx_q   <= idx_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
              addr_q  <= addr_q + STEP_BYTES;
              state_q <= REQ;
            end
          end
        end
        DRAIN: begin
          if (bus.data_rvalid_i) begin
            state_q <= IDLE;
          end
        end
        DONE: begin
          if (bus.mret_valid_i) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Store-conflict window from the next load up to the frame top; the window
  // may wrap past the end of the 4 KiB page when sp sits on a page boundary.
  always_comb begin
    in_range_s = 1'b0;
    if (addr_q[11:3] <= frame_end_q) begin
      in_range_s = (bus.page_offset_i[11:3] >= addr_q[11:3]) &&
                   (bus.page_offset_i[11:3] <= frame_end_q);
    end else begin
      in_range_s = (bus.page_offset_i[11:3] >= addr_q[11:3]) ||
                   (bus.page_offset_i[11:3] <= frame_end_q);
    end
  end

  // Output decode; abort and rvalid act in the same cycle they arrive.
  always_comb begin
    busy_s = (state_q == REQ) || (state_q == TAG) ||
             (state_q == WAIT_DATA) || (state_q == DRAIN);

    bus.restore_ack_o      = (state_q == IDLE) && bus.restore_valid_i;
    bus.busy_o             = busy_s;
    bus.mret_ready_o       = (state_q == IDLE) || (state_q == DONE);
    bus.data_req_o         = (state_q == REQ) && !bus.abort_i;
    bus.tag_valid_o        = (state_q == TAG) && !bus.abort_i;
    bus.kill_req_o         = (state_q == TAG) && bus.abort_i;
    bus.shadow_reg_we_o    = (state_q == WAIT_DATA) && bus.data_rvalid_i && !bus.abort_i;
    bus.shadow_reg_waddr_o = bus.shadow_reg_we_o ? idx_q : {ADDR_WIDTH{1'b0}};
    bus.shadow_reg_wdata_o = bus.shadow_reg_we_o ? bus.data_rdata_i : {DATA_WIDTH{1'b0}};
    bus.address_index_o    = addr_ext_s[INDEX_WIDTH-1:0];
    bus.address_tag_o      = addr_ext_s[IT_WIDTH-1:INDEX_WIDTH];
    bus.data_we_o          = 1'b0;
    bus.data_be_o          = {BYTES{1'b1}};
    bus.data_size_o        = (DATA_WIDTH == 64) ? 2'b11 : 2'b10;
    bus.page_offset_matches_o = busy_s && in_range_s;

    if (busy_s) begin
      bus.load_level_o = NUM_SAVES - idx_q;
    end else if (state_q == DONE) begin
      bus.load_level_o = {ADDR_WIDTH{1'b0}};
    end else begin
      bus.load_level_o = LAST_IDX;
    end
  end

endmodule
